// File: rtl/mod129_stream_if.sv
// Word-in / residue-out stream bundle for mod129_stream_accumulator.
interface mod129_stream_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_residue;
  logic [CNT_W-1:0] out_words;
  logic             out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_residue, out_words, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_residue, out_words, out_overflow
  );
endinterface

// File: rtl/mod129_stream_accumulator.sv
// Folds a MSW-first stream of 64-bit words into N mod 129 and reports it with the word count.

// 64-bit word mod 129 using 2^7 = -1 (mod 129): alternating sum of 7-bit digits.
module x_modulo_129 (
  input  logic [63:0] data,
  output logic [7:0]  residue_c
);
  localparam int unsigned SUM_W = 11;

  logic [SUM_W-1:0] pos;
  logic [SUM_W-1:0] neg;
  logic [SUM_W-1:0] diff;

  // pos <= 635, neg <= 509; the 516 offset (4*129) keeps diff positive
  always_comb begin
    pos = SUM_W'(data[6:0])   + SUM_W'(data[20:14]) + SUM_W'(data[34:28]) +
          SUM_W'(data[48:42]) + SUM_W'(data[62:56]);
    neg = SUM_W'(data[13:7])  + SUM_W'(data[27:21]) + SUM_W'(data[41:35]) +
          SUM_W'(data[55:49]) + SUM_W'(data[63]);
    diff = pos + SUM_W'(516) - neg;
    residue_c = 8'(diff % SUM_W'(129));
  end
endmodule

module mod129_stream_accumulator #(
  parameter int unsigned CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  mod129_stream_if.slave bus
);
  localparam int unsigned RES_W  = 8;
  localparam int unsigned FOLD_W = 10;

  typedef enum logic [1:0] {ACC, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [RES_W-1:0] w_c, w_q;
  logic             v_q, l_q;
  logic [RES_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [FOLD_W-1:0] fold;
  logic [RES_W-1:0] fold_red;
  logic             xfer, hs;

  logic             in_ready_d, out_valid_d, out_overflow_d;
  logic [RES_W-1:0] out_residue_d;
  logic [CNT_W-1:0] out_words_d;

  assign xfer = bus.in_valid && bus.in_ready;
  assign hs   = bus.out_valid && bus.out_ready;

  x_modulo_129 u_word_mod (
    .data      (bus.in_data),
    .residue_c (w_c)
  );

  // Stage 1: registered word residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      v_q <= 1'b0;
      l_q <= 1'b0;
    end else begin
      v_q <= xfer;
      if (xfer) begin
        w_q <= w_c;
        l_q <= bus.in_last;
      end
    end
  end

  // Stage 2 fold: 127*R = -2R (mod 129), so w + 258 - 2R lies in 2..386
  always_comb begin
    fold = FOLD_W'(w_q) + FOLD_W'(258) - FOLD_W'({r_q, 1'b0});
    if (fold >= FOLD_W'(258))      fold_red = RES_W'(fold - FOLD_W'(258));
    else if (fold >= FOLD_W'(129)) fold_red = RES_W'(fold - FOLD_W'(129));
    else                           fold_red = RES_W'(fold);
  end

  always_comb begin
    r_d   = r_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (hs) begin
      r_d   = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (v_q) r_d = fold_red;
      if (xfer) begin
        if (&cnt_q) ovf_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      r_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (xfer && bus.in_last) state_d = FLUSH;
      FLUSH:   if (v_q && l_q)          state_d = DONE;
      DONE:    if (hs)                  state_d = ACC;
      default:                          state_d = ACC;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state
  always_comb begin
    in_ready_d     = 1'b0;
    out_valid_d    = 1'b0;
    out_residue_d  = '0;
    out_words_d    = '0;
    out_overflow_d = 1'b0;
    case (state_d)
      ACC:  in_ready_d = 1'b1;
      DONE: begin
        out_valid_d    = 1'b1;
        out_residue_d  = r_d;
        out_words_d    = cnt_d;
        out_overflow_d = ovf_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready     <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_residue  <= '0;
      bus.out_words    <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      bus.in_ready     <= in_ready_d;
      bus.out_valid    <= out_valid_d;
      bus.out_residue  <= out_residue_d;
      bus.out_words    <= out_words_d;
      bus.out_overflow <= out_overflow_d;
    end
  end
endmodule

// File: tb/tb_mod129_stream_accumulator.sv
// Bench for mod129_stream_accumulator: vector table plus hand sequences, scoreboard-checked results.
module tb_mod129_stream_accumulator;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_W_S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod129_stream_if #(.CNT_W(CNT_W))   bus_a ();
  mod129_stream_if #(.CNT_W(CNT_W_S)) bus_b ();

  mod129_stream_accumulator #(.CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mod129_stream_accumulator #(.CNT_W(CNT_W_S)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct packed {
    logic [7:0]  res;
    logic [15:0] words;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [2:0][63:0] w;
    int               n;
    int               gap;
    logic [7:0]       res;
    logic [15:0]      words;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] r, input logic [63:0] w);
    logic [31:0] t;
    t = 32'd127 * 32'(r) + 32'(w % 64'd129);
    return 8'(t % 32'd129);
  endfunction

  // Scoreboard: pop and compare on every result handshake
  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      if (sb_a.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected_result: got residue %0d, want none", bus_a.out_residue);
      end else begin
        exp_t e;
        e = sb_a.pop_front();
        check("a_residue", 32'(bus_a.out_residue), 32'(e.res));
        check("a_words", 32'(bus_a.out_words), 32'(e.words));
        check("a_overflow", 32'(bus_a.out_overflow), 32'(e.ovf));
      end
    end
    if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
      if (sb_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected_result: got residue %0d, want none", bus_b.out_residue);
      end else begin
        exp_t e;
        e = sb_b.pop_front();
        check("b_residue", 32'(bus_b.out_residue), 32'(e.res));
        check("b_words", 32'(bus_b.out_words), 32'(e.words));
        check("b_overflow", 32'(bus_b.out_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic drive(input bit sel, input logic v, input logic [63:0] d, input logic l);
    if (sel) begin
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l;
    end else begin
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  // Entered and left at posedge+1; returns after the word has transferred
  task automatic send_word(input bit sel, input logic [63:0] d, input bit last, input int gap);
    for (int g = 0; g < gap; g++) begin
      drive(sel, 1'b0, {$urandom, $urandom}, 1'($urandom));
      @(posedge clk); #1;
    end
    drive(sel, 1'b1, d, last);
    for (int b = 0; b <= 60; b++) begin
      @(negedge clk);
      if (rdy(sel)) break;
      if (b == 60) begin
        n_cmp++; n_fail++;
        $display("FAIL in_ready_timeout: got 0, want 1");
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic send_msg(input bit sel, input logic [4:0][63:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++)
      send_word(sel, w[i], i == n - 1, (gap < 0) ? int'($urandom_range(0, 2)) : gap);
  endtask

  task automatic drain(input string name);
    for (int b = 0; b <= 100; b++) begin
      if (sb_a.size() == 0 && sb_b.size() == 0) break;
      if (b == 100) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_drain_timeout: got %0d pending, want 0", name, sb_a.size() + sb_b.size());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic set_vec(input int i, input int n, input int gap, input logic [7:0] res,
                         input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
    tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2;
    tbl[i].n = n; tbl[i].gap = gap; tbl[i].res = res; tbl[i].words = 16'(n);
  endtask

  initial begin
    logic [4:0][63:0] msg;
    logic [7:0]       r;
    int               n;
    logic [63:0]      all1;

    all1 = '1;
    set_vec(0, 1, 0, 8'd75,  64'hCC, 64'h0, 64'h0);
    set_vec(1, 2, 0, 8'd127, 64'h1,  64'h0, 64'h0);
    set_vec(2, 2, 0, 8'd128, 64'h1,  64'h1, 64'h0);
    set_vec(3, 2, 0, 8'd0,   64'h1,  64'h2, 64'h0);
    for (int g = 0; g < 4; g++) set_vec(4 + g, 3, g, 8'd120, all1, all1, all1);

    drive(1'b0, 1'b0, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_residue", 32'(bus_a.out_residue), 32'd0);
    check("rst_out_words", 32'(bus_a.out_words), 32'd0);
    check("rst_out_overflow", 32'(bus_a.out_overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency of a single-word message
    sb_a.push_back('{res: 8'd75, words: 16'd1, ovf: 1'b0});
    drive(1'b0, 1'b1, 64'hCC, 1'b1);
    @(negedge clk);
    while (!bus_a.in_ready) @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    check("lat_t1_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("lat_t1_in_ready", 32'(bus_a.in_ready), 32'd0);
    @(negedge clk);
    check("lat_t2_out_valid", 32'(bus_a.out_valid), 32'd1);
    @(negedge clk);
    check("lat_t3_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("lat_t3_out_valid", 32'(bus_a.out_valid), 32'd0);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      msg = '0;
      for (int k = 0; k < 3; k++) msg[k] = tbl[i].w[k];
      sb_a.push_back('{res: tbl[i].res, words: tbl[i].words, ovf: 1'b0});
      send_msg(1'b0, msg, tbl[i].n, tbl[i].gap);
    end
    drain("table");

    // Random messages against the reference model
    for (int m = 0; m < 6; m++) begin
      n = int'($urandom_range(1, 5));
      r = '0;
      for (int k = 0; k < 5; k++) begin
        msg[k] = {$urandom, $urandom};
        if (k < n) r = model_step(r, msg[k]);
      end
      sb_a.push_back('{res: r, words: 16'(n), ovf: 1'b0});
      send_msg(1'b0, msg, n, -1);
    end
    drain("random");

    // Backpressure in DONE: outputs hold, input pulses ignored
    bus_a.out_ready = 1'b0;
    sb_a.push_back('{res: 8'd128, words: 16'd2, ovf: 1'b0});
    msg = '0; msg[0] = 64'h1; msg[1] = 64'h1;
    send_msg(1'b0, msg, 2, 0);
    for (int b = 0; b < 20 && !bus_a.out_valid; b++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
      @(negedge clk);
      check("hold_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("hold_out_residue", 32'(bus_a.out_residue), 32'd128);
      check("hold_out_words", 32'(bus_a.out_words), 32'd2);
      check("hold_in_ready", 32'(bus_a.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_after_hs_valid", 32'(bus_a.out_valid), 32'd0);
    @(posedge clk); #1;
    sb_a.push_back('{res: 8'd75, words: 16'd1, ovf: 1'b0});
    msg = '0; msg[0] = 64'hCC;
    send_msg(1'b0, msg, 1, 0);
    drain("hold");

    // Narrow counter saturates and flags overflow
    r = '0;
    for (int k = 0; k < 5; k++) begin
      msg[k] = {$urandom, $urandom};
      r = model_step(r, msg[k]);
    end
    sb_b.push_back('{res: r, words: 16'd3, ovf: 1'b1});
    send_msg(1'b1, msg, 5, 0);
    sb_b.push_back('{res: 8'd75, words: 16'd1, ovf: 1'b0});
    msg = '0; msg[0] = 64'hCC;
    send_msg(1'b1, msg, 1, 0);
    drain("overflow");

    // Reset mid-message discards the partial message
    send_word(1'b0, 64'h1234, 1'b0, 0);
    send_word(1'b0, 64'h5678, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("midrst_out_residue", 32'(bus_a.out_residue), 32'd0);
    check("midrst_out_words", 32'(bus_a.out_words), 32'd0);
    check("midrst_out_overflow", 32'(bus_a.out_overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_a.push_back('{res: 8'd0, words: 16'd1, ovf: 1'b0});
    send_word(1'b0, 64'h81, 1'b1, 0);
    drain("midrst");
    repeat (10) @(posedge clk);
    #1;
    check("final_pending", 32'(sb_a.size() + sb_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
